// File: rtl/match_engine.sv
// Memory-match game engine: accepts card selections, fetches their values from
// card memory, then scores a completed set or holds a mismatch on display.
module match_engine #(
   parameter int NUM_CARDS = 36,
   parameter int VAL_W     = 5,
   parameter int ADDR_W    = 6,
   parameter int GROUP     = 2,
   parameter int HOLD_CYC  = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 restart,
   input  logic                 sel,
   input  logic [ADDR_W-1:0]    cursor,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [VAL_W-1:0]     mem_data,
   output logic [2:0]           sel_cnt,
   output logic [4*ADDR_W-1:0]  sel_locs,
   output logic [NUM_CARDS-1:0] matched,
   output logic [5:0]           sets_found,
   output logic                 found_p,
   output logic                 miss_p,
   output logic                 busy,
   output logic                 game_over
);
   localparam int         HOLD_W     = $clog2(HOLD_CYC + 1);
   localparam logic [5:0] TOTAL_SETS = 6'(NUM_CARDS / GROUP);
   localparam logic [2:0] GROUP_CNT  = 3'(GROUP);

   typedef enum logic [2:0] {IDLE, FETCH, CHECK, HOLD, DONE} state_t;

   state_t               state_q, state_d;
   logic                 fetch_wait_q, fetch_wait_d;
   logic [ADDR_W-1:0]    locs_q [4];
   logic [ADDR_W-1:0]    locs_d [4];
   logic [VAL_W-1:0]     vals_q [4];
   logic [VAL_W-1:0]     vals_d [4];
   logic [2:0]           cnt_q, cnt_d;
   logic [NUM_CARDS-1:0] matched_q, matched_d;
   logic [5:0]           sets_q, sets_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;

   logic cursor_held, cursor_removed, cursor_ok, all_equal, set_hit, hold_end;

   // Only slots below sel_cnt are live, so an all-ones cursor never aliases an empty slot.
   always_comb begin
      cursor_held    = 1'b0;
      cursor_removed = 1'b0;
      all_equal      = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if ((3'(k) < cnt_q) && (locs_q[k] == cursor)) cursor_held = 1'b1;
      end
      for (int i = 0; i < NUM_CARDS; i++) begin
         if ((cursor == ADDR_W'(i)) && matched_q[i]) cursor_removed = 1'b1;
      end
      for (int k = 1; k < GROUP; k++) begin
         if (vals_q[k] != vals_q[0]) all_equal = 1'b0;
      end
   end

   assign cursor_ok = (32'(cursor) < 32'(NUM_CARDS)) && !cursor_removed && !cursor_held;
   assign set_hit   = (state_q == CHECK) && (cnt_q == GROUP_CNT) && all_equal;
   assign hold_end  = (state_q == HOLD) && (hold_q == '0);

   always_comb begin
      state_d      = state_q;
      fetch_wait_d = fetch_wait_q;
      locs_d       = locs_q;
      vals_d       = vals_q;
      cnt_d        = cnt_q;
      matched_d    = matched_q;
      sets_d       = sets_q;
      addr_d       = addr_q;
      hold_d       = hold_q;
      if (restart) begin
         state_d      = IDLE;
         fetch_wait_d = 1'b0;
         locs_d       = '{default: {ADDR_W{1'b1}}};
         vals_d       = '{default: '0};
         cnt_d        = '0;
         matched_d    = '0;
         sets_d       = '0;
         addr_d       = '0;
         hold_d       = '0;
      end else if (!enable && (state_q != DONE)) begin
         state_d      = IDLE;
         fetch_wait_d = 1'b0;
         locs_d       = '{default: {ADDR_W{1'b1}}};
         cnt_d        = '0;
         hold_d       = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel && cursor_ok) begin
                  locs_d[cnt_q[1:0]] = cursor;
                  addr_d             = cursor;
                  fetch_wait_d       = 1'b1;
                  state_d            = FETCH;
               end
            end
            // First FETCH cycle covers the memory's read latency; the second captures.
            FETCH: begin
               if (fetch_wait_q) begin
                  fetch_wait_d = 1'b0;
               end else begin
                  vals_d[cnt_q[1:0]] = mem_data;
                  cnt_d              = cnt_q + 3'd1;
                  state_d            = CHECK;
               end
            end
            CHECK: begin
               if (cnt_q != GROUP_CNT) begin
                  state_d = IDLE;
               end else if (all_equal) begin
                  for (int k = 0; k < GROUP; k++) begin
                     for (int i = 0; i < NUM_CARDS; i++) begin
                        if (locs_q[k] == ADDR_W'(i)) matched_d[i] = 1'b1;
                     end
                  end
                  sets_d  = sets_q + 6'd1;
                  locs_d  = '{default: {ADDR_W{1'b1}}};
                  cnt_d   = '0;
                  state_d = (sets_d == TOTAL_SETS) ? DONE : IDLE;
               end else begin
                  hold_d  = HOLD_W'(HOLD_CYC);
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (hold_q == '0) begin
                  locs_d  = '{default: {ADDR_W{1'b1}}};
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         fetch_wait_q <= 1'b0;
         locs_q       <= '{default: {ADDR_W{1'b1}}};
         vals_q       <= '{default: '0};
         cnt_q        <= '0;
         matched_q    <= '0;
         sets_q       <= '0;
         addr_q       <= '0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         fetch_wait_q <= fetch_wait_d;
         locs_q       <= locs_d;
         vals_q       <= vals_d;
         cnt_q        <= cnt_d;
         matched_q    <= matched_d;
         sets_q       <= sets_d;
         addr_q       <= addr_d;
         hold_q       <= hold_d;
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_locs
      assign sel_locs[k*ADDR_W +: ADDR_W] = locs_q[k];
   end

   // Pulses mark the deciding cycle and are suppressed when that decision is overridden.
   assign found_p    = set_hit && enable && !restart;
   assign miss_p     = hold_end && enable && !restart;
   assign mem_addr   = addr_q;
   assign sel_cnt    = cnt_q;
   assign matched    = matched_q;
   assign sets_found = sets_q;
   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign game_over  = (state_q == DONE);

endmodule

// File: tb/tb_match_engine.sv
// Bench for match_engine: a queue-based game model runs beside the DUT and all
// outputs are compared every cycle, plus directed scenarios with literal checks.
module tb_match_engine;
   localparam int NUM_CARDS  = 36;
   localparam int VAL_W      = 5;
   localparam int ADDR_W     = 6;
   localparam int GROUP      = 2;
   localparam int HOLD_CYC   = 8;
   localparam int TOTAL_SETS = NUM_CARDS / GROUP;

   logic                 clock = 1'b0;
   logic                 reset_n, enable, restart, sel;
   logic [ADDR_W-1:0]    cursor, mem_addr;
   logic [VAL_W-1:0]     mem_data;
   logic [2:0]           sel_cnt;
   logic [4*ADDR_W-1:0]  sel_locs;
   logic [NUM_CARDS-1:0] matched;
   logic [5:0]           sets_found;
   logic                 found_p, miss_p, busy, game_over;

   logic [VAL_W-1:0] mem [64];
   int  total = 0;
   int  bad   = 0;
   bit  checking = 1'b0;

   int  heldLocs[$];
   int  heldVals[$];
   bit  mMatched [NUM_CARDS];
   int  mSets, mSince, mHoldLeft, mAddr;
   bit  mInHold, mOver;

   logic [4*ADDR_W-1:0]  expLocs;
   logic [NUM_CARDS-1:0] expMatched;
   logic                 expFound, expMiss;

   int foundAt, missAt;
   int perm [NUM_CARDS];

   match_engine #(
      .NUM_CARDS(NUM_CARDS), .VAL_W(VAL_W), .ADDR_W(ADDR_W),
      .GROUP(GROUP), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .restart(restart),
      .sel(sel), .cursor(cursor), .mem_addr(mem_addr), .mem_data(mem_data),
      .sel_cnt(sel_cnt), .sel_locs(sel_locs), .matched(matched),
      .sets_found(sets_found), .found_p(found_p), .miss_p(miss_p),
      .busy(busy), .game_over(game_over)
   );

   always #5 clock = ~clock;

   always @(posedge clock) mem_data <= mem[mem_addr];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      heldLocs.delete();
      heldVals.delete();
      foreach (mMatched[i]) mMatched[i] = 1'b0;
      mSets = 0; mSince = -1; mHoldLeft = 0; mAddr = 0;
      mInHold = 1'b0; mOver = 1'b0;
   endtask

   function automatic bit allSame();
      foreach (heldVals[i]) if (heldVals[i] != heldVals[0]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit isLegal(input int c);
      if (c >= NUM_CARDS) return 1'b0;
      if (mMatched[c]) return 1'b0;
      foreach (heldLocs[i]) if (heldLocs[i] == c) return 1'b0;
      return 1'b1;
   endfunction

   // mSince counts edges since the card was accepted: value lands on the second, verdict on the third.
   task automatic modelStep();
      if (restart) begin
         modelReset();
      end else if (mOver) begin
      end else if (!enable) begin
         heldLocs.delete(); heldVals.delete();
         mSince = -1; mInHold = 1'b0; mHoldLeft = 0;
      end else if (mInHold) begin
         if (mHoldLeft == 0) begin
            heldLocs.delete(); heldVals.delete();
            mInHold = 1'b0;
         end else begin
            mHoldLeft--;
         end
      end else if (mSince == 0) begin
         mSince = 1;
      end else if (mSince == 1) begin
         heldVals.push_back(int'(mem[heldLocs[$]]));
         mSince = 2;
      end else if (mSince == 2) begin
         mSince = -1;
         if (heldVals.size() == GROUP) begin
            if (allSame()) begin
               foreach (heldLocs[i]) mMatched[heldLocs[i]] = 1'b1;
               mSets++;
               heldLocs.delete(); heldVals.delete();
               if (mSets == TOTAL_SETS) mOver = 1'b1;
            end else begin
               mInHold = 1'b1;
               mHoldLeft = HOLD_CYC;
            end
         end
      end else if (sel && isLegal(int'(cursor))) begin
         heldLocs.push_back(int'(cursor));
         mAddr = int'(cursor);
         mSince = 0;
      end
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) modelReset();
      else modelStep();
   end

   always @(negedge clock) begin
      if (checking) begin
         for (int k = 0; k < 4; k++) begin
            if (k < heldLocs.size()) expLocs[k*ADDR_W +: ADDR_W] = ADDR_W'(heldLocs[k]);
            else expLocs[k*ADDR_W +: ADDR_W] = '1;
         end
         for (int i = 0; i < NUM_CARDS; i++) expMatched[i] = mMatched[i];
         expFound = (mSince == 2) && (heldVals.size() == GROUP) && allSame() && enable && !restart;
         expMiss  = mInHold && (mHoldLeft == 0) && enable && !restart;
         checkOutput("sel_cnt", 64'(sel_cnt), 64'(heldVals.size()));
         checkOutput("sel_locs", 64'(sel_locs), 64'(expLocs));
         checkOutput("matched", 64'(matched), 64'(expMatched));
         checkOutput("sets_found", 64'(sets_found), 64'(mSets));
         checkOutput("mem_addr", 64'(mem_addr), 64'(mAddr));
         checkOutput("found_p", 64'(found_p), 64'(expFound));
         checkOutput("miss_p", 64'(miss_p), 64'(expMiss));
         checkOutput("busy", 64'(busy), 64'((mSince >= 0) || mInHold));
         checkOutput("game_over", 64'(game_over), 64'(mOver));
         checkOutput("pulse_excl", 64'(found_p & miss_p), 64'd0);
      end
   end

   task automatic applyStimulus(input logic s, input logic [ADDR_W-1:0] c, input logic e, input logic r);
      @(negedge clock);
      #1;
      sel = s; cursor = c; enable = e; restart = r;
   endtask

   // n counts negedges after the select is presented; edges after the sampling edge are n-1.
   task automatic pickCard(input int loc, output int fAt, output int mAt);
      bit done = 1'b0;
      fAt = 0; mAt = 0;
      applyStimulus(1'b1, ADDR_W'(loc), 1'b1, 1'b0);
      for (int n = 1; n <= 40 && !done; n++) begin
         @(negedge clock);
         if (n == 1) begin #1; sel = 1'b0; end
         if (found_p && fAt == 0) fAt = n;
         if (miss_p && mAt == 0) mAt = n;
         if (!busy) done = 1'b1;
      end
      if (!done) checkOutput("pick_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      reset_n = 1'b0; enable = 1'b0; restart = 1'b0; sel = 1'b0; cursor = '0;
      repeat (3) @(negedge clock);
      checking = 1'b1;
      @(negedge clock);
      checkOutput("reset_sel_cnt", 64'(sel_cnt), 64'd0);
      checkOutput("reset_sel_locs", 64'(sel_locs), 64'hFF_FFFF);
      checkOutput("reset_matched", 64'(matched), 64'd0);
      checkOutput("reset_sets", 64'(sets_found), 64'd0);
      checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_game_over", 64'(game_over), 64'd0);
      #1 reset_n = 1'b1;

      // Matching pair: found_p two edges after the second select is sampled.
      mem[0] = 5'd7; mem[1] = 5'd7;
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      pickCard(0, foundAt, missAt);
      checkOutput("first_pick_cnt", 64'(sel_cnt), 64'd1);
      checkOutput("first_pick_nofound", 64'(foundAt), 64'd0);
      pickCard(1, foundAt, missAt);
      checkOutput("found_latency", 64'(foundAt - 1), 64'd2);
      checkOutput("pair_matched", 64'(matched[1:0]), 64'd3);
      checkOutput("pair_sets", 64'(sets_found), 64'd1);

      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("restart_matched", 64'(matched), 64'd0);
      checkOutput("restart_sets", 64'(sets_found), 64'd0);

      // Mismatch: CHECK at edge 2, nine HOLD cycles (counter 8..0), miss_p on the last.
      mem[0] = 5'd3; mem[2] = 5'd4;
      pickCard(0, foundAt, missAt);
      pickCard(2, foundAt, missAt);
      checkOutput("miss_latency", 64'(missAt - 1), 64'd11);
      checkOutput("miss_nofound", 64'(foundAt), 64'd0);
      checkOutput("miss_cnt", 64'(sel_cnt), 64'd0);
      checkOutput("miss_matched", 64'(matched), 64'd0);

      mem[8] = 5'd1; mem[9] = 5'd1; mem[5] = 5'd6;
      pickCard(8, foundAt, missAt);
      pickCard(9, foundAt, missAt);
      pickCard(5, foundAt, missAt);
      pickCard(5, foundAt, missAt);
      pickCard(8, foundAt, missAt);
      pickCard(40, foundAt, missAt);
      checkOutput("ignored_cnt", 64'(sel_cnt), 64'd1);
      checkOutput("ignored_locs", 64'(sel_locs), 64'hFF_FFC5);

      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("enable_drop_cnt", 64'(sel_cnt), 64'd0);
      checkOutput("enable_drop_sets", 64'(sets_found), 64'd1);

      mem[3] = 5'd1; mem[4] = 5'd2;
      pickCard(3, foundAt, missAt);
      applyStimulus(1'b1, 6'd4, 1'b1, 1'b0);
      applyStimulus(1'b0, 6'd4, 1'b1, 1'b0);
      repeat (5) @(negedge clock);
      checkOutput("in_hold_busy", 64'(busy), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("hold_reset_busy", 64'(busy), 64'd0);
      checkOutput("hold_reset_cnt", 64'(sel_cnt), 64'd0);
      checkOutput("hold_reset_locs", 64'(sel_locs), 64'hFF_FFFF);
      checkOutput("hold_reset_matched", 64'(matched), 64'd0);
      checkOutput("hold_reset_miss", 64'(miss_p), 64'd0);
      repeat (3) @(negedge clock);
      #1 reset_n = 1'b1;

      // Full game on a shuffled board, pairs picked in order.
      for (int i = 0; i < NUM_CARDS; i++) perm[i] = i;
      for (int i = NUM_CARDS - 1; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(i, 0));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int p = 0; p < TOTAL_SETS; p++) begin
         mem[perm[2*p]] = VAL_W'(p);
         mem[perm[2*p+1]] = VAL_W'(p);
      end
      for (int p = 0; p < TOTAL_SETS; p++) begin
         pickCard(perm[2*p], foundAt, missAt);
         pickCard(perm[2*p+1], foundAt, missAt);
      end
      checkOutput("done_game_over", 64'(game_over), 64'd1);
      checkOutput("done_sets", 64'(sets_found), 64'd18);
      checkOutput("done_matched", 64'(matched), 64'hF_FFFF_FFFF);
      pickCard(perm[0], foundAt, missAt);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("done_sel_ignored", 64'(sel_cnt), 64'd0);
      checkOutput("done_stays", 64'(game_over), 64'd1);

      for (int i = 0; i < 64; i++) mem[i] = VAL_W'($urandom_range(3, 0));
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      for (int c = 0; c < 3000; c++) begin
         applyStimulus(($urandom % 3) == 0, ADDR_W'($urandom_range(40, 0)),
                       ($urandom % 40) != 0, ($urandom % 300) == 0);
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
